// File: rtl/mic3_window_stats.sv
// Per-window min/max/peak-to-peak/mean/absdev over 2^WIN_LOG2 mic samples.
// One record per window, held on a valid/ready port; records that cannot be held are counted.
module mic3_window_stats #(
    parameter int WIN_LOG2 = 10,
    parameter int MIDSCALE = 2048
) (
    input  logic        sysclk,
    input  logic        rst,
    input  logic        s_valid,
    input  logic [11:0] s_data,
    output logic        m_valid,
    input  logic        m_ready,
    output logic [11:0] m_min,
    output logic [11:0] m_max,
    output logic [11:0] m_p2p,
    output logic [11:0] m_mean,
    output logic [11:0] m_absdev,
    output logic [7:0]  overrun_cnt
);

    localparam int AW = 12 + WIN_LOG2;
    localparam logic [11:0] MID = 12'(MIDSCALE);
    localparam logic [WIN_LOG2-1:0] LAST = '1;

    typedef enum logic {
        EMPTY,
        FULL
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [WIN_LOG2-1:0] cnt;
    logic [11:0]         run_min;
    logic [11:0]         run_max;
    logic [AW-1:0]       sum;
    logic [AW-1:0]       abssum;

    logic          first;
    logic          close;
    logic          load;
    logic          drop;
    logic [11:0]   dev;
    logic [11:0]   nxt_min;
    logic [11:0]   nxt_max;
    logic [AW-1:0] nxt_sum;
    logic [AW-1:0] nxt_abs;

    // Next-accumulator values include the current sample, so a closing
    // window's record can be taken straight from them.
    always_comb begin
        first   = (cnt == '0);
        close   = s_valid && (cnt == LAST);
        dev     = (s_data >= MID) ? (s_data - MID) : (MID - s_data);
        nxt_min = (first || s_data < run_min) ? s_data : run_min;
        nxt_max = (first || s_data > run_max) ? s_data : run_max;
        nxt_sum = (first ? '0 : sum) + AW'(s_data);
        nxt_abs = (first ? '0 : abssum) + AW'(dev);
    end

    always_ff @(posedge sysclk) begin
        if (rst) begin
            cnt     <= '0;
            run_min <= '0;
            run_max <= '0;
            sum     <= '0;
            abssum  <= '0;
        end else if (s_valid) begin
            cnt     <= cnt + 1'b1;
            run_min <= nxt_min;
            run_max <= nxt_max;
            sum     <= nxt_sum;
            abssum  <= nxt_abs;
        end
    end

    always_ff @(posedge sysclk) begin
        if (rst) begin
            state <= EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            EMPTY: begin
                if (close) begin
                    state_nxt = FULL;
                end
            end
            FULL: begin
                if (m_ready && !close) begin
                    state_nxt = EMPTY;
                end
            end
            default: state_nxt = EMPTY;
        endcase
    end

    // A close while the held record is not being taken loses the new one.
    always_comb begin
        m_valid = (state == FULL);
        load    = close && ((state == EMPTY) || m_ready);
        drop    = close && (state == FULL) && !m_ready;
    end

    always_ff @(posedge sysclk) begin
        if (rst) begin
            m_min    <= '0;
            m_max    <= '0;
            m_p2p    <= '0;
            m_mean   <= '0;
            m_absdev <= '0;
        end else if (load) begin
            m_min    <= nxt_min;
            m_max    <= nxt_max;
            m_p2p    <= nxt_max - nxt_min;
            m_mean   <= nxt_sum[AW-1:WIN_LOG2];
            m_absdev <= nxt_abs[AW-1:WIN_LOG2];
        end
    end

    always_ff @(posedge sysclk) begin
        if (rst) begin
            overrun_cnt <= '0;
        end else if (drop && overrun_cnt != 8'hFF) begin
            overrun_cnt <= overrun_cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_mic3_window_stats.sv
// Bench for mic3_window_stats with 4-sample windows.
// Directed scenarios plus random traffic against a window-level model.
module tb_mic3_window_stats;

    localparam int W = 2;
    localparam int N = 4;

    typedef struct packed {
        logic [11:0] mn;
        logic [11:0] mx;
        logic [11:0] p2p;
        logic [11:0] mean;
        logic [11:0] absdev;
    } rec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        s_valid = 1'b0;
    logic [11:0] s_data = '0;
    logic        m_ready = 1'b0;
    logic        m_valid;
    logic [11:0] m_min;
    logic [11:0] m_max;
    logic [11:0] m_p2p;
    logic [11:0] m_mean;
    logic [11:0] m_absdev;
    logic [7:0]  overrun_cnt;

    int total = 0;
    int bad = 0;
    bit chk_en = 1'b0;

    mic3_window_stats #(.WIN_LOG2(W), .MIDSCALE(2048)) dut (
        .sysclk(clk),
        .rst(rst),
        .s_valid(s_valid),
        .s_data(s_data),
        .m_valid(m_valid),
        .m_ready(m_ready),
        .m_min(m_min),
        .m_max(m_max),
        .m_p2p(m_p2p),
        .m_mean(m_mean),
        .m_absdev(m_absdev),
        .overrun_cnt(overrun_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Window statistics straight from the definitions.
    function automatic rec_t stats(input logic [11:0] a, input logic [11:0] b,
                                   input logic [11:0] c, input logic [11:0] d);
        int s[4];
        int mn, mx, sm, ab;
        rec_t r;
        s = '{int'(a), int'(b), int'(c), int'(d)};
        mn = 4095; mx = 0; sm = 0; ab = 0;
        for (int i = 0; i < N; i++) begin
            if (s[i] < mn) mn = s[i];
            if (s[i] > mx) mx = s[i];
            sm += s[i];
            ab += (s[i] >= 2048) ? s[i] - 2048 : 2048 - s[i];
        end
        r.mn = 12'(mn);
        r.mx = 12'(mx);
        r.p2p = 12'(mx - mn);
        r.mean = 12'(sm / N);
        r.absdev = 12'(ab / N);
        return r;
    endfunction

    int          mcnt = 0;
    logic [11:0] mbuf [0:3];
    logic        exp_valid = 1'b0;
    rec_t        exp_rec = '0;
    int          exp_ovr = 0;

    always @(posedge clk) begin
        if (rst) begin
            mcnt <= 0;
            exp_valid <= 1'b0;
            exp_rec <= '0;
            exp_ovr <= 0;
        end else begin
            if (s_valid) begin
                mbuf[mcnt] <= s_data;
                mcnt <= (mcnt == N - 1) ? 0 : mcnt + 1;
            end
            if (s_valid && mcnt == N - 1) begin
                if (!exp_valid || m_ready) begin
                    exp_valid <= 1'b1;
                    exp_rec <= stats(mbuf[0], mbuf[1], mbuf[2], s_data);
                end else if (exp_ovr != 255) begin
                    exp_ovr <= exp_ovr + 1;
                end
            end else if (exp_valid && m_ready) begin
                exp_valid <= 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("cyc_valid", 32'(m_valid), 32'(exp_valid));
            check("cyc_min", 32'(m_min), 32'(exp_rec.mn));
            check("cyc_max", 32'(m_max), 32'(exp_rec.mx));
            check("cyc_p2p", 32'(m_p2p), 32'(exp_rec.p2p));
            check("cyc_mean", 32'(m_mean), 32'(exp_rec.mean));
            check("cyc_absdev", 32'(m_absdev), 32'(exp_rec.absdev));
            check("cyc_ovr", 32'(overrun_cnt), 32'(exp_ovr));
        end
    end

    task automatic sample(input logic [11:0] x);
        s_valid = 1'b1;
        s_data = x;
        @(negedge clk);
        s_valid = 1'b0;
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic expect_rec(input string tag, input int mn, input int mx,
                              input int mean, input int absdev);
        check({tag, "_valid"}, 32'(m_valid), 32'd1);
        check({tag, "_min"}, 32'(m_min), 32'(mn));
        check({tag, "_max"}, 32'(m_max), 32'(mx));
        check({tag, "_p2p"}, 32'(m_p2p), 32'(mx - mn));
        check({tag, "_mean"}, 32'(m_mean), 32'(mean));
        check({tag, "_absdev"}, 32'(m_absdev), 32'(absdev));
    endtask

    initial begin
        int ovr0;
        logic [11:0] t2 [4];
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk_en = 1'b1;
        check("rst_valid", 32'(m_valid), 32'd0);
        check("rst_min", 32'(m_min), 32'd0);
        check("rst_mean", 32'(m_mean), 32'd0);
        check("rst_ovr", 32'(overrun_cnt), 32'd0);

        // Midscale window and one-cycle latency.
        m_ready = 1'b1;
        repeat (3) sample(12'd2048);
        check("lat_before", 32'(m_valid), 32'd0);
        sample(12'd2048);
        expect_rec("mid", 2048, 2048, 2048, 0);
        @(negedge clk);
        check("mid_taken", 32'(m_valid), 32'd0);

        // Extremes with random idle gaps.
        t2 = '{12'd0, 12'd4095, 12'd1000, 12'd3000};
        for (int i = 0; i < N; i++) begin
            repeat ($urandom_range(0, 20)) @(negedge clk);
            sample(t2[i]);
        end
        expect_rec("ext", 0, 4095, 2023, 1523);
        @(negedge clk);

        // Held record, second window dropped.
        pulse_rst();
        m_ready = 1'b0;
        for (int i = 1; i <= 8; i++) sample(12'(i));
        expect_rec("hold", 1, 4, 2, 2045);
        check("hold_ovr", 32'(overrun_cnt), 32'd1);
        m_ready = 1'b1;
        @(negedge clk);
        check("hold_drain", 32'(m_valid), 32'd0);

        // Close coincides with acceptance of the held record.
        pulse_rst();
        m_ready = 1'b0;
        sample(12'd10); sample(12'd20); sample(12'd30); sample(12'd40);
        ovr0 = int'(overrun_cnt);
        sample(12'd50); sample(12'd60); sample(12'd70);
        m_ready = 1'b1;
        sample(12'd80);
        expect_rec("swap", 50, 80, 65, 1983);
        check("swap_ovr", 32'(overrun_cnt), 32'(ovr0));
        @(negedge clk);

        // Reset mid-window discards partial samples.
        m_ready = 1'b1;
        sample(12'd7); sample(12'd9);
        pulse_rst();
        check("mrst_valid", 32'(m_valid), 32'd0);
        repeat (4) sample(12'd100);
        expect_rec("mrst", 100, 100, 100, 1948);
        @(negedge clk);

        // Saturating overrun count.
        pulse_rst();
        m_ready = 1'b0;
        for (int i = 0; i < 301 * N; i++) sample(12'($urandom_range(0, 4095)));
        check("sat_ovr", 32'(overrun_cnt), 32'd255);
        check("sat_valid", 32'(m_valid), 32'd1);

        // Random traffic.
        for (int i = 0; i < 5000; i++) begin
            s_valid = ($urandom_range(0, 2) != 0);
            s_data = 12'($urandom_range(0, 4095));
            m_ready = (i % 1000 < 500) ? ($urandom_range(0, 3) != 0)
                                       : ($urandom_range(0, 5) == 0);
            rst = ($urandom_range(0, 999) == 0);
            @(negedge clk);
        end
        s_valid = 1'b0;
        rst = 1'b0;
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
